// File: rtl/alu_pkg.sv
// Opcode set and widths shared by the Nibbler sequential ALU and its multiplier.
package alu_pkg;

   localparam int ALU_OP_W = 5;

   typedef enum logic [ALU_OP_W-1:0] {
      OP_PASSA = 5'b00000,
      OP_SHL   = 5'b00010,
      OP_SHR   = 5'b00011,
      OP_SUB   = 5'b00110,
      OP_ADD   = 5'b01001,
      OP_MUL   = 5'b01100,
      OP_NOR   = 5'b10001,
      OP_PASSB = 5'b11010
   } alu_op_t;

   function automatic logic is_zero(input logic [63:0] value);
      return (value == 64'd0);
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one partial product per cycle, N cycles per product.
// Only present when ALU_SEQ_MUL_EN is defined.
`ifdef ALU_SEQ_MUL_EN
module alu_mul_seq #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           go,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           fin,
   output logic [2*N-1:0] prod
);

   localparam int CW = $clog2(N + 1);

   logic [N-1:0]  mcand;
   logic [N-1:0]  hi;
   logic [N-1:0]  lo;
   logic [CW-1:0] cnt;
   logic [N:0]    sum;

   assign sum  = lo[0] ? ({1'b0, hi} + {1'b0, mcand}) : {1'b0, hi};
   // fin and prod describe the step taken at the coming edge, so the parent
   // can register the finished product on the same edge busy drops.
   assign fin  = busy && (cnt == CW'(N - 1));
   assign prod = {sum, lo[N-1:1]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy  <= 1'b0;
         cnt   <= '0;
         mcand <= '0;
         hi    <= '0;
         lo    <= '0;
      end else if (go) begin
         busy  <= 1'b1;
         cnt   <= '0;
         mcand <= a;
         hi    <= '0;
         lo    <= b;
      end else if (busy) begin
         hi  <= sum[N:1];
         lo  <= {sum[0], lo[N-1:1]};
         cnt <= cnt + 1'b1;
         if (fin) busy <= 1'b0;
      end
   end

endmodule
`endif

// File: rtl/alu_seq.sv
// Nibbler sequential ALU: single-cycle logic/arith/shift ops plus optional
// multi-cycle MUL (enabled by ALU_SEQ_MUL_EN), all outputs registered.
module alu_seq
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [N-1:0]        A,
   input  logic [N-1:0]        B,
   input  logic [ALU_OP_W-1:0] S,
   input  logic                nCin,
   output logic                busy,
   output logic                done,
   output logic [N-1:0]        Result,
   output logic [N-1:0]        Hi,
   output logic                Cout,
   output logic                eq,
   output logic                neg
);

   logic           cin;
   logic           accept;
   logic           single;
   logic           mul_go;
   logic           mul_fin;
   logic [2*N-1:0] mul_prod;
   logic [N-1:0]   res_c;
   logic           cout_c;
   logic [N:0]     sum_c;

   assign cin    = ~nCin;
   assign accept = start && !busy;
   assign single = accept && !mul_go;

`ifdef ALU_SEQ_MUL_EN
   logic mul_busy;

   assign mul_go = accept && (S == OP_MUL);
   assign busy   = mul_busy;

   alu_mul_seq #(.N(N)) u_mul (
      .clk  (clk),
      .rst_n(rst_n),
      .go   (mul_go),
      .a    (A),
      .b    (B),
      .busy (mul_busy),
      .fin  (mul_fin),
      .prod (mul_prod)
   );
`else
   assign mul_go   = 1'b0;
   assign busy     = 1'b0;
   assign mul_fin  = 1'b0;
   assign mul_prod = '0;
`endif

   always_comb begin
      res_c  = '0;
      cout_c = 1'b0;
      sum_c  = '0;
      case (S)
         OP_PASSA: res_c = A;
         OP_PASSB: res_c = B;
         OP_ADD: begin
            sum_c           = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, cin};
            {cout_c, res_c} = sum_c;
         end
         OP_SUB: begin
            sum_c           = {1'b0, A} + {1'b0, ~B} + {{N{1'b0}}, cin};
            {cout_c, res_c} = sum_c;
         end
         OP_NOR: res_c = ~(A | B);
         OP_SHL: begin
            res_c  = {A[N-2:0], cin};
            cout_c = A[N-1];
         end
         OP_SHR: begin
            res_c  = {cin, A[N-1:1]};
            cout_c = A[0];
         end
         default: ;
      endcase
   end

   // Output stage: flags are computed from the value being written, not the old one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Result <= '0;
         Hi     <= '0;
         Cout   <= 1'b0;
         eq     <= 1'b1;
         neg    <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (mul_fin) begin
            Result <= mul_prod[N-1:0];
            Hi     <= mul_prod[2*N-1:N];
            Cout   <= |mul_prod[2*N-1:N];
            eq     <= is_zero(64'(mul_prod[N-1:0]));
            neg    <= mul_prod[N-1];
            done   <= 1'b1;
         end else if (single) begin
            Result <= res_c;
            Hi     <= '0;
            Cout   <= cout_c;
            eq     <= is_zero(64'(res_c));
            neg    <= res_c[N-1];
            done   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (N=4): directed plan cases plus random ops vs. an arithmetic model.
module tb_alu_seq;

   localparam int N    = 4;
   localparam int MASK = (1 << N) - 1;
`ifdef ALU_SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [N-1:0]   A = '0;
   logic [N-1:0]   B = '0;
   logic [4:0]     S = '0;
   logic           nCin = 1'b1;
   logic           busy, done, Cout, eq, neg;
   logic [N-1:0]   Result, Hi;

   alu_seq #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .S(S), .nCin(nCin),
      .busy(busy), .done(done), .Result(Result), .Hi(Hi), .Cout(Cout), .eq(eq), .neg(neg)
   );

   always #5 clk = ~clk;

   typedef struct {
      int res;
      int hi;
      int cout;
      int eq;
      int neg;
      int at;
   } exp_t;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   passes = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act == req) passes++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
   endtask

   // Reference behaviour written directly from the opcode table with integer arithmetic.
   function automatic exp_t model(input int a, input int b, input int s, input int ncin);
      exp_t e;
      int   cin, t, p;
      cin = (ncin != 0) ? 0 : 1;
      e.res = 0; e.hi = 0; e.cout = 0; e.at = 0;
      case (s)
         5'b00000: e.res = a;
         5'b11010: e.res = b;
         5'b01001: begin t = a + b + cin;            e.res = t % (MASK + 1); e.cout = (t > MASK); end
         5'b00110: begin t = a + (MASK - b) + cin;   e.res = t % (MASK + 1); e.cout = (t > MASK); end
         5'b10001: e.res = MASK - (a | b);
         5'b00010: begin e.res = ((a * 2) + cin) % (MASK + 1); e.cout = a / (1 << (N - 1)); end
         5'b00011: begin e.res = (a / 2) + cin * (1 << (N - 1)); e.cout = a % 2; end
         5'b01100: if (MUL_EN) begin
            p = a * b;
            e.res = p % (MASK + 1); e.hi = p / (MASK + 1); e.cout = (e.hi != 0);
         end
         default: ;
      endcase
      e.eq  = (e.res == 0);
      e.neg = (e.res >= (1 << (N - 1)));
      return e;
   endfunction

   // Wait for the ALU to be free, present one op, push its expected response.
   task automatic issue(input int a, input int b, input int s, input int ncin);
      exp_t e;
      int   w = 0;
      @(negedge clk);
      while (busy && w < 64) begin
         @(negedge clk);
         w++;
      end
      if (w >= 64) chk("busy_timeout", w, 0);
      start = 1'b1; A = N'(a); B = N'(b); S = 5'(s); nCin = ncin[0];
      e = model(a, b, s, ncin);
      e.at = cyc + 1 + ((s == 5'b01100 && MUL_EN) ? N : 0);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      A = N'($urandom); B = N'($urandom); S = 5'($urandom); nCin = 1'($urandom);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_busy"},   busy,   0);
      chk({tag, "_done"},   done,   0);
      chk({tag, "_result"}, Result, 0);
      chk({tag, "_hi"},     Hi,     0);
      chk({tag, "_cout"},   Cout,   0);
      chk({tag, "_eq"},     eq,     1);
      chk({tag, "_neg"},    neg,    0);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done: got done=1 with no op outstanding, expected done=0 (cycle %0d)", cyc);
         end else begin
            e = exp_q.pop_front();
            chk("result",  Result, e.res);
            chk("hi",      Hi,     e.hi);
            chk("cout",    Cout,   e.cout);
            chk("eq",      eq,     e.eq);
            chk("neg",     neg,    e.neg);
            chk("latency", cyc,    e.at);
         end
      end
   end

   initial begin
      int codes[8] = '{5'b00000, 5'b11010, 5'b01001, 5'b00110, 5'b10001, 5'b00010, 5'b00011, 5'b01100};
      int s;

      rst_n = 1'b0; start = 1'b1; S = 5'b01001; A = 4'h9; B = 4'h8;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1; start = 1'b0;

      issue(4'h9, 4'h8, 5'b01001, 1);
      issue(4'hF, 4'h0, 5'b01001, 0);
      issue(4'h3, 4'h5, 5'b00110, 0);
      issue(4'h5, 4'h5, 5'b00110, 0);
      issue(4'b1001, 4'h0, 5'b00010, 1);
      issue(4'b0110, 4'h0, 5'b00011, 0);
      issue(4'hA, 4'h5, 5'b10001, 1);
      issue(4'h7, 4'hC, 5'b00000, 0);
      issue(4'h7, 4'hC, 5'b11010, 0);
      issue(4'hF, 4'hF, 5'b11111, 0);

      issue(4'd11, 4'd7, 5'b01100, 1);
      if (MUL_EN) begin
         @(negedge clk);
         chk("busy_during_mul", busy, 1);
         start = 1'b1; A = 4'h1; B = 4'h1; S = 5'b01001; nCin = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      end
      issue(4'd11, 4'd7, 5'b01100, 1);
      issue(4'hF, 4'hF, 5'b01100, 1);
      issue(4'h2, 4'h3, 5'b01001, 1);

      // Reset two cycles into a multiply: the product must never appear.
      issue(4'hD, 4'h9, 5'b01100, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      exp_q.delete();
      check_reset_state("abort");
      rst_n = 1'b1;

      for (int i = 0; i < 150; i++) begin
         s = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : codes[$urandom_range(0, 7)];
         issue(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), s, int'($urandom_range(0, 1)));
      end

      repeat (N + 4) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
